trg_time_stats: RTL and testbench

Statistics accumulator directly downstream of the trigger timer. It watches the timer's STOP strobe and latched TIME value, and accumulates per-run statistics of the measured trigger latencies: count, minimum, maximum, sum and last value. A request/acknowledge snapshot port freezes a coherent copy of all statistics for slow-control readout.

---
 rtl/trg_time_stats.sv | 203 ++++++++++++++++++++
 tb/tb_trg_time_stats.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trg_time_stats.sv
// -----------------------------------------------------------------------------
// trg_time_stats
//
// Accumulates per-run statistics of trigger latencies measured by the upstream
// trigger timer. For each sample it tracks the count, minimum, maximum, sum and
// last value. A request/acknowledge snapshot port freezes a coherent copy of
// every statistic for slow-control readout.
//
// Parameters:
//   Width      width of the incoming TIME measurement
//   CntWidth   width of the measurement counter
//   SumWidth   width of the latency sum accumulator (>= Width)
//   ClrOnRead  when 1, a snapshot also clears the live statistics
//
// Ports:
//   CLK     in   system clock, shared with the trigger timer
//   RST_N   in   synchronous active-low reset
//   CLR     in   synchronous clear of the live statistics
//   STOP    in   timer STOP strobe; TIME is valid on the following cycle
//   TIME    in   timer latched measurement
//   RD_REQ  in   snapshot request (level or pulse)
//   RD_ACK  out  one-cycle snapshot acknowledge
//   N_MEAS  out  snapshot of the measurement count
//   T_MIN   out  snapshot of the minimum TIME (all-ones when N_MEAS = 0)
//   T_MAX   out  snapshot of the maximum TIME
//   T_SUM   out  snapshot of the sum of TIME values
//   T_LAST  out  snapshot of the most recent TIME
//   OVFL    out  snapshot flag: count or sum saturated
// -----------------------------------------------------------------------------
module trg_time_stats #(
    parameter int Width     = 8,
    parameter int CntWidth  = 16,
    parameter int SumWidth  = 24,
    parameter bit ClrOnRead = 1'b0
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                CLR,
    input  logic                STOP,
    input  logic [Width-1:0]    TIME,
    input  logic                RD_REQ,
    output logic                RD_ACK,
    output logic [CntWidth-1:0] N_MEAS,
    output logic [Width-1:0]    T_MIN,
    output logic [Width-1:0]    T_MAX,
    output logic [SumWidth-1:0] T_SUM,
    output logic [Width-1:0]    T_LAST,
    output logic                OVFL
);

    localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};
    localparam logic [SumWidth-1:0] SumMax = {SumWidth{1'b1}};
    localparam logic [Width-1:0]    MinEmpty = {Width{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Timer presents TIME one edge after STOP, so the strobe is delayed once.
    logic stop_d;

    // Live statistics.
    logic [CntWidth-1:0] cnt_q;
    logic [SumWidth-1:0] sum_q;
    logic [Width-1:0]    min_q;
    logic [Width-1:0]    max_q;
    logic [Width-1:0]    last_q;
    logic                ovfl_q;

    // Next-state values for the live statistics.
    logic [CntWidth-1:0] cnt_d;
    logic [SumWidth-1:0] sum_d;
    logic [Width-1:0]    min_d;
    logic [Width-1:0]    max_d;
    logic [Width-1:0]    last_d;
    logic                ovfl_d;

    logic take;      // snapshot happens on this edge
    logic clr_live;  // live statistics restart on this edge

    // Starting point for this edge: either the current live values or the
    // empty set, so a sample coinciding with a clear becomes the first sample.
    logic [CntWidth-1:0] base_cnt;
    logic [SumWidth-1:0] base_sum;
    logic [Width-1:0]    base_min;
    logic [Width-1:0]    base_max;
    logic [Width-1:0]    base_last;
    logic                base_ovfl;
    logic [SumWidth:0]   sum_ext;

    // ------------------------------------------------------------------
    // Snapshot handshake FSM: next state and snapshot strobe
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (RD_REQ) begin
                    take    = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                // A held request yields a single snapshot; re-arm on low.
                if (!RD_REQ) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Live statistics update
    // ------------------------------------------------------------------
    always_comb begin
        clr_live = CLR || (ClrOnRead && take);

        base_cnt  = cnt_q;
        base_sum  = sum_q;
        base_min  = min_q;
        base_max  = max_q;
        base_last = last_q;
        base_ovfl = ovfl_q;
        if (clr_live) begin
            base_cnt  = '0;
            base_sum  = '0;
            base_min  = MinEmpty;
            base_max  = '0;
            base_last = '0;
            base_ovfl = 1'b0;
        end

        sum_ext = {1'b0, base_sum} + {{(SumWidth + 1 - Width){1'b0}}, TIME};

        cnt_d  = base_cnt;
        sum_d  = base_sum;
        min_d  = base_min;
        max_d  = base_max;
        last_d = base_last;
        ovfl_d = base_ovfl;
        if (stop_d) begin
            cnt_d  = (base_cnt == CntMax) ? base_cnt : base_cnt + 1'b1;
            sum_d  = sum_ext[SumWidth] ? SumMax : sum_ext[SumWidth-1:0];
            min_d  = (TIME < base_min) ? TIME : base_min;
            max_d  = (TIME > base_max) ? TIME : base_max;
            last_d = TIME;
            // Overflow flags a sample that could not be fully accounted for.
            ovfl_d = base_ovfl || (base_cnt == CntMax) || (base_sum == SumMax);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the snapshot below relies on that to exclude a
    // sample landing on the same edge.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            stop_d  <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            min_q   <= MinEmpty;
            max_q   <= '0;
            last_q  <= '0;
            ovfl_q  <= 1'b0;
            RD_ACK  <= 1'b0;
            N_MEAS  <= '0;
            T_MIN   <= MinEmpty;
            T_MAX   <= '0;
            T_SUM   <= '0;
            T_LAST  <= '0;
            OVFL    <= 1'b0;
        end else begin
            state_q <= state_d;
            stop_d  <= STOP;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            min_q   <= min_d;
            max_q   <= max_d;
            last_q  <= last_d;
            ovfl_q  <= ovfl_d;
            RD_ACK  <= take;
            if (take) begin
                N_MEAS <= cnt_q;
                T_MIN  <= min_q;
                T_MAX  <= max_q;
                T_SUM  <= sum_q;
                T_LAST <= last_q;
                OVFL   <= ovfl_q;
            end
        end
    end

endmodule

// File: tb/tb_trg_time_stats.sv
// -----------------------------------------------------------------------------
// tb_trg_time_stats
//
// Two instances: d0 with a narrow counter/sum (CntWidth=4, SumWidth=12) to
// reach saturation quickly, d1 with default widths and clear-on-read. A
// transaction model pushes the expected snapshot when a request is driven; a
// monitor pops and compares whenever RD_ACK is seen.
// -----------------------------------------------------------------------------
module tb_trg_time_stats;

    typedef struct {
        int n;
        int mn;
        int mx;
        int sm;
        int ls;
        int ov;
    } snap_t;

    logic clk;
    logic rst_n;
    logic stop_i [2];
    logic clr_i  [2];
    logic req_i  [2];
    logic [7:0] time_i [2];
    logic ack_o [2];

    logic [3:0]  n_meas0;
    logic [7:0]  t_min0, t_max0, t_last0;
    logic [11:0] t_sum0;
    logic        ovfl0;

    logic [15:0] n_meas1;
    logic [7:0]  t_min1, t_max1, t_last1;
    logic [23:0] t_sum1;
    logic        ovfl1;

    int n_cmp;
    int n_err;

    // Transaction model state, per instance.
    int m_cnt [2], m_sum [2], m_min [2], m_max [2], m_last [2], m_ovfl [2];
    int cnt_max [2] = '{15, 65535};
    int sum_max [2] = '{4095, 16777215};
    bit cor [2]     = '{1'b0, 1'b1};
    bit pend_stop [2];
    int pend_time [2];
    int ack_cnt [2];

    snap_t q0[$];
    snap_t q1[$];

    trg_time_stats #(
        .Width(8), .CntWidth(4), .SumWidth(12), .ClrOnRead(1'b0)
    ) u_dut0 (
        .CLK(clk), .RST_N(rst_n), .CLR(clr_i[0]), .STOP(stop_i[0]),
        .TIME(time_i[0]), .RD_REQ(req_i[0]), .RD_ACK(ack_o[0]),
        .N_MEAS(n_meas0), .T_MIN(t_min0), .T_MAX(t_max0), .T_SUM(t_sum0),
        .T_LAST(t_last0), .OVFL(ovfl0)
    );

    trg_time_stats #(
        .Width(8), .CntWidth(16), .SumWidth(24), .ClrOnRead(1'b1)
    ) u_dut1 (
        .CLK(clk), .RST_N(rst_n), .CLR(clr_i[1]), .STOP(stop_i[1]),
        .TIME(time_i[1]), .RD_REQ(req_i[1]), .RD_ACK(ack_o[1]),
        .N_MEAS(n_meas1), .T_MIN(t_min1), .T_MAX(t_max1), .T_SUM(t_sum1),
        .T_LAST(t_last1), .OVFL(ovfl1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int d);
        m_cnt[d]  = 0;
        m_sum[d]  = 0;
        m_min[d]  = 255;
        m_max[d]  = 0;
        m_last[d] = 0;
        m_ovfl[d] = 0;
    endtask

    task automatic model_sample(input int d, input int t);
        if (m_cnt[d] == cnt_max[d] || m_sum[d] == sum_max[d]) m_ovfl[d] = 1;
        if (m_cnt[d] < cnt_max[d]) m_cnt[d] = m_cnt[d] + 1;
        m_sum[d] = (m_sum[d] + t > sum_max[d]) ? sum_max[d] : m_sum[d] + t;
        if (t < m_min[d]) m_min[d] = t;
        if (t > m_max[d]) m_max[d] = t;
        m_last[d] = t;
    endtask

    task automatic push_snap(input int d);
        snap_t e;
        e.n  = m_cnt[d];
        e.mn = m_min[d];
        e.mx = m_max[d];
        e.sm = m_sum[d];
        e.ls = m_last[d];
        e.ov = m_ovfl[d];
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // One clock cycle of stimulus for instance d. The model is updated in the
    // order the edge resolves events: snapshot, then clear, then sample.
    task automatic step(input int d, input bit stop, input int tv, input bit clr,
                        input bit req, input bit snap, input bit rstn = 1'b1);
        rst_n     = rstn;
        stop_i[d] = stop;
        clr_i[d]  = clr;
        req_i[d]  = req;
        if (pend_stop[d]) time_i[d] = 8'(pend_time[d]);
        if (!rstn) begin
            model_reset(0);
            model_reset(1);
            pend_stop[0] = 1'b0;
            pend_stop[1] = 1'b0;
        end else begin
            if (snap) push_snap(d);
            if (clr || (snap && cor[d])) model_reset(d);
            if (pend_stop[d]) model_sample(d, pend_time[d]);
            pend_stop[d] = stop;
            pend_time[d] = tv;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d, input int n = 1);
        for (int i = 0; i < n; i++) step(d, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    // Full snapshot: request, drop, one spare cycle for the monitor.
    task automatic snapshot(input int d);
        step(d, 1'b0, 0, 1'b0, 1'b1, 1'b1);
        idle(d, 2);
    endtask

    task automatic cmp_snap(input int d, input snap_t e, input int n, input int mn,
                            input int mx, input int sm, input int ls, input int ov);
        string p;
        p = (d == 0) ? "d0" : "d1";
        check({p, "_snap_n_meas"}, n, e.n);
        check({p, "_snap_t_min"}, mn, e.mn);
        check({p, "_snap_t_max"}, mx, e.mx);
        check({p, "_snap_t_sum"}, sm, e.sm);
        check({p, "_snap_t_last"}, ls, e.ls);
        check({p, "_snap_ovfl"}, ov, e.ov);
    endtask

    // Scoreboard monitor: every acknowledge must match a queued expectation.
    always @(negedge clk) begin
        snap_t e;
        if (ack_o[0] === 1'b1) begin
            ack_cnt[0]++;
            check("d0_ack_expected", int'(q0.size() != 0), 1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                cmp_snap(0, e, n_meas0, t_min0, t_max0, t_sum0, t_last0, ovfl0);
            end
        end
        if (ack_o[1] === 1'b1) begin
            ack_cnt[1]++;
            check("d1_ack_expected", int'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                cmp_snap(1, e, n_meas1, t_min1, t_max1, t_sum1, t_last1, ovfl1);
            end
        end
    end

    initial begin
        int a0;
        n_cmp = 0;
        n_err = 0;
        ack_cnt = '{0, 0};
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            stop_i[d] = 1'b0;
            clr_i[d]  = 1'b0;
            req_i[d]  = 1'b0;
            time_i[d] = 8'd0;
            pend_stop[d] = 1'b0;
            pend_time[d] = 0;
            model_reset(d);
        end

        // Reset state.
        step(0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_rd_ack", ack_o[0], 0);
        check("rst_n_meas", n_meas0, 0);
        check("rst_t_min", t_min0, 255);
        check("rst_t_max", t_max0, 0);
        check("rst_t_sum", t_sum0, 0);
        check("rst_t_last", t_last0, 0);
        check("rst_ovfl", ovfl0, 0);
        idle(0);

        // Basic samples 5, 12, 3.
        step(0, 1'b1, 5, 1'b0, 1'b0, 1'b0);
        step(0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        step(0, 1'b1, 12, 1'b0, 1'b0, 1'b0);
        step(0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        step(0, 1'b1, 3, 1'b0, 1'b0, 1'b0);
        idle(0, 2);
        a0 = ack_cnt[0];
        snapshot(0);
        idle(0, 2);
        check("basic_ack_count", ack_cnt[0] - a0, 1);
        check("basic_n_meas", n_meas0, 3);
        check("basic_t_min", t_min0, 3);
        check("basic_t_max", t_max0, 12);
        check("basic_t_sum", t_sum0, 20);
        check("basic_t_last", t_last0, 3);

        // Clear alone must not disturb the snapshot outputs.
        step(0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        idle(0);
        check("clr_keeps_n_meas", n_meas0, 3);

        // Back-to-back STOPs, then a held request.
        step(0, 1'b1, 7, 1'b0, 1'b0, 1'b0);
        step(0, 1'b1, 8, 1'b0, 1'b0, 1'b0);
        step(0, 1'b1, 9, 1'b0, 1'b0, 1'b0);
        step(0, 1'b1, 10, 1'b0, 1'b0, 1'b0);
        idle(0, 2);
        a0 = ack_cnt[0];
        step(0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) step(0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        check("held_req_one_ack", ack_cnt[0] - a0, 1);
        check("b2b_n_meas", n_meas0, 4);
        check("b2b_t_sum", t_sum0, 34);
        idle(0, 2);
        snapshot(0);
        check("rearm_second_ack", ack_cnt[0] - a0, 2);

        // Sample coincident with snapshot is excluded.
        step(0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        step(0, 1'b1, 20, 1'b0, 1'b0, 1'b0);
        step(0, 1'b1, 30, 1'b0, 1'b0, 1'b0);
        step(0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
        idle(0, 2);
        check("coinc_n_meas", n_meas0, 1);
        check("coinc_t_sum", t_sum0, 20);

        // Saturation with 20 samples of 255.
        for (int i = 0; i < 20; i++) step(0, 1'b1, 255, 1'b0, 1'b0, 1'b0);
        idle(0, 2);
        snapshot(0);
        check("sat_n_meas", n_meas0, 15);
        check("sat_t_sum", t_sum0, 4095);
        check("sat_ovfl", ovfl0, 1);

        // Clear coincident with a sample of 9.
        step(0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        check("clr_keeps_ovfl", ovfl0, 1);
        step(0, 1'b1, 9, 1'b0, 1'b0, 1'b0);
        step(0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        idle(0);
        snapshot(0);
        check("clrsmp_n_meas", n_meas0, 1);
        check("clrsmp_t_min", t_min0, 9);
        check("clrsmp_t_max", t_max0, 9);
        check("clrsmp_t_sum", t_sum0, 9);
        check("clrsmp_t_last", t_last0, 9);
        check("clrsmp_ovfl", ovfl0, 0);

        // Clear-on-read instance.
        step(1, 1'b1, 4, 1'b0, 1'b0, 1'b0);
        step(1, 1'b1, 6, 1'b0, 1'b0, 1'b0);
        idle(1, 2);
        snapshot(1);
        check("cor1_n_meas", n_meas1, 2);
        check("cor1_t_sum", t_sum1, 10);
        snapshot(1);
        check("cor2_n_meas", n_meas1, 0);
        check("cor2_t_min", t_min1, 255);
        check("cor2_t_max", t_max1, 0);

        // Reset while in ACK and during a STOP.
        step(0, 1'b1, 50, 1'b0, 1'b0, 1'b0);
        a0 = ack_cnt[0];
        step(0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
        step(0, 1'b1, 77, 1'b0, 1'b1, 1'b0, 1'b0);
        check("midrst_rd_ack", ack_o[0], 0);
        check("midrst_n_meas", n_meas0, 0);
        check("midrst_t_min", t_min0, 255);
        check("midrst_t_max", t_max0, 0);
        check("midrst_t_sum", t_sum0, 0);
        check("midrst_t_last", t_last0, 0);
        check("midrst_ovfl", ovfl0, 0);
        // Request still high: an IDLE FSM snapshots the empty set at once.
        step(0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
        idle(0, 3);
        check("midrst_ack_count", ack_cnt[0] - a0, 2);

        check("d0_queue_drained", q0.size(), 0);
        check("d1_queue_drained", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
